// File: rtl/rob_retire_ctrl_if.sv
// Handshake bundle between the ROB head, the retirement controller and its downstream consumers.
interface rob_retire_ctrl_if #(
  parameter int ENTRY_WIDTH = 32,
  parameter int N_ENTRIES   = 8
);
  localparam int PTR_WIDTH = $clog2(N_ENTRIES);

  logic                   deq_valid;
  logic [ENTRY_WIDTH-1:0] deq_data;
  logic [PTR_WIDTH-1:0]   deq_addr;
  logic                   deq_ready;

  logic                   retire_valid;
  logic                   retire_ready;
  logic [PTR_WIDTH-1:0]   retire_tag;
  logic                   retire_rd_we;
  logic [4:0]             retire_rd_arch;
  logic [ENTRY_WIDTH-9:0] retire_payload;

  logic                   exc_valid;
  logic                   exc_ready;
  logic [PTR_WIDTH-1:0]   exc_tag;
  logic [ENTRY_WIDTH-9:0] exc_payload;

  logic                   flush;
  logic                   order_err;
  logic [31:0]            retire_count;

  modport master (
    input  deq_valid, deq_data, deq_addr, retire_ready, exc_ready,
    output deq_ready, retire_valid, retire_tag, retire_rd_we, retire_rd_arch, retire_payload,
           exc_valid, exc_tag, exc_payload, flush, order_err, retire_count
  );

  modport slave (
    output deq_valid, deq_data, deq_addr, retire_ready, exc_ready,
    input  deq_ready, retire_valid, retire_tag, retire_rd_we, retire_rd_arch, retire_payload,
           exc_valid, exc_tag, exc_payload, flush, order_err, retire_count
  );
endinterface

// File: rtl/rob_retire_ctrl.sv
// In-order ROB retirement: pops done head entries into a one-entry retire slot and turns an
// excepting head into an exception handshake followed by a single-cycle flush.
module rob_retire_ctrl #(
  parameter int ENTRY_WIDTH = 32,
  parameter int N_ENTRIES   = 8
) (
  input logic               clk,
  input logic               rst_aL,
  rob_retire_ctrl_if.master bus
);
  localparam int PTR_WIDTH = $clog2(N_ENTRIES);
  localparam int PL_WIDTH  = ENTRY_WIDTH - 8;
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

  typedef enum logic [1:0] {S_RUN, S_EXC, S_FLUSH} state_e;

  state_e               state_q, state_d;
  logic [PTR_WIDTH-1:0] exp_ptr_q;
  logic                 retire_valid_q;
  logic [PTR_WIDTH-1:0] retire_tag_q;
  logic                 retire_rd_we_q;
  logic [4:0]           retire_rd_arch_q;
  logic [PL_WIDTH-1:0]  retire_payload_q;
  logic                 exc_valid_q;
  logic [PTR_WIDTH-1:0] exc_tag_q;
  logic [PL_WIDTH-1:0]  exc_payload_q;
  logic                 order_err_q;
  logic [31:0]          retire_count_q;

  logic head_done, head_exc, slot_free;
  logic pop, pop_norm, pop_exc, exc_fire;

  assign head_done = bus.deq_data[0];
  assign head_exc  = bus.deq_data[1];
  assign slot_free = !retire_valid_q | bus.retire_ready;
  assign exc_fire  = exc_valid_q & bus.exc_ready;

  always_ff @(posedge clk) begin
    if (!rst_aL) state_q <= S_RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if (pop_exc)  state_d = S_EXC;
      S_EXC:   if (exc_fire) state_d = S_FLUSH;
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Pops are only issued in RUN and never while reset is asserted.
  always_comb begin
    pop      = 1'b0;
    pop_norm = 1'b0;
    pop_exc  = 1'b0;
    if (rst_aL && state_q == S_RUN) begin
      pop      = bus.deq_valid & head_done & slot_free;
      pop_norm = pop & !head_exc;
      pop_exc  = pop & head_exc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      exp_ptr_q        <= '0;
      retire_valid_q   <= 1'b0;
      retire_tag_q     <= '0;
      retire_rd_we_q   <= 1'b0;
      retire_rd_arch_q <= '0;
      retire_payload_q <= '0;
      exc_valid_q      <= 1'b0;
      exc_tag_q        <= '0;
      exc_payload_q    <= '0;
      order_err_q      <= 1'b0;
      retire_count_q   <= '0;
    end else begin
      if (pop_norm) begin
        retire_valid_q   <= 1'b1;
        retire_tag_q     <= bus.deq_addr;
        retire_rd_we_q   <= bus.deq_data[2];
        retire_rd_arch_q <= bus.deq_data[7:3];
        retire_payload_q <= bus.deq_data[ENTRY_WIDTH-1:8];
      end else if (bus.retire_ready) begin
        retire_valid_q <= 1'b0;
      end

      if (retire_valid_q && bus.retire_ready) retire_count_q <= retire_count_q + 32'd1;

      if (pop_exc) begin
        exc_valid_q   <= 1'b1;
        exc_tag_q     <= bus.deq_addr;
        exc_payload_q <= bus.deq_data[ENTRY_WIDTH-1:8];
      end else if (exc_fire) begin
        exc_valid_q <= 1'b0;
      end

      // The flush empties the ROB, so the next head comes from index 0.
      if (state_q == S_FLUSH) exp_ptr_q <= '0;
      else if (pop)           exp_ptr_q <= exp_ptr_q + PTR_ONE;

      if (pop && bus.deq_addr != exp_ptr_q) order_err_q <= 1'b1;
    end
  end

  assign bus.deq_ready      = pop;
  assign bus.retire_valid   = retire_valid_q;
  assign bus.retire_tag     = retire_tag_q;
  assign bus.retire_rd_we   = retire_rd_we_q;
  assign bus.retire_rd_arch = retire_rd_arch_q;
  assign bus.retire_payload = retire_payload_q;
  assign bus.exc_valid      = exc_valid_q;
  assign bus.exc_tag        = exc_tag_q;
  assign bus.exc_payload    = exc_payload_q;
  assign bus.flush          = (state_q == S_FLUSH);
  assign bus.order_err      = order_err_q;
  assign bus.retire_count   = retire_count_q;
endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Scoreboard bench for rob_retire_ctrl: popped entries are queued and matched against retirements.
module tb_rob_retire_ctrl;
  logic clk;
  logic rst_aL;
  int   n_chk;
  int   n_fail;

  typedef struct {
    logic [2:0]  tag;
    logic        we;
    logic [4:0]  arch;
    logic [23:0] pl;
  } ret_t;

  ret_t sb[$];

  rob_retire_ctrl_if #(.ENTRY_WIDTH(32), .N_ENTRIES(8)) bus ();

  rob_retire_ctrl #(.ENTRY_WIDTH(32), .N_ENTRIES(8)) dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input bit exc, input bit we, input logic [4:0] arch,
                                     input logic [23:0] pl);
    return {pl, arch, we, exc, 1'b1};
  endfunction

  // Retirement monitor: every accepted retirement must match the oldest popped entry.
  always @(negedge clk) begin
    ret_t e;
    if (rst_aL && bus.retire_valid && bus.retire_ready) begin
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("retire_tag",  64'(bus.retire_tag), 64'(e.tag));
        chk("retire_we",   64'(bus.retire_rd_we), 64'(e.we));
        chk("retire_arch", 64'(bus.retire_rd_arch), 64'(e.arch));
        chk("retire_pl",   64'(bus.retire_payload), 64'(e.pl));
      end
    end
  end

  task automatic present(input logic [2:0] addr, input logic [31:0] data);
    bit popped;
    popped        = 1'b0;
    bus.deq_valid = 1'b1;
    bus.deq_addr  = addr;
    bus.deq_data  = data;
    for (int i = 0; i < 20 && !popped; i++) begin
      @(negedge clk);
      if (bus.deq_ready) begin
        popped = 1'b1;
        if (!data[1]) sb.push_back('{addr, data[2], data[7:3], data[31:8]});
      end
    end
    chk("pop_timeout", 64'(popped), 64'd1);
    @(posedge clk); #1;
    bus.deq_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.deq_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_aL           = 1'b0;
    bus.deq_valid    = 1'b1;
    bus.deq_addr     = 3'd0;
    bus.deq_data     = mk(1'b0, 1'b1, 5'd1, 24'h1);
    bus.retire_ready = 1'b1;
    bus.exc_ready    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_deq_ready", 64'(bus.deq_ready), 64'd0);
    chk("rst_retire_valid", 64'(bus.retire_valid), 64'd0);
    chk("rst_retire_fields", 64'({bus.retire_tag, bus.retire_rd_we, bus.retire_rd_arch,
                                  bus.retire_payload}), 64'd0);
    chk("rst_exc", 64'({bus.exc_valid, bus.exc_tag, bus.exc_payload}), 64'd0);
    chk("rst_flush", 64'(bus.flush), 64'd0);
    chk("rst_order_err", 64'(bus.order_err), 64'd0);
    chk("rst_count", 64'(bus.retire_count), 64'd0);
    @(posedge clk); #1;
    bus.deq_valid = 1'b0;
    rst_aL        = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a_data, b_data, c_data, nd_data;
    n_chk  = 0;
    n_fail = 0;
    rst_aL = 1'b0;
    bus.deq_valid    = 1'b0;
    bus.deq_addr     = '0;
    bus.deq_data     = '0;
    bus.retire_ready = 1'b1;
    bus.exc_ready    = 1'b0;
    do_reset();

    // Streaming through a full wrap of the ROB index.
    for (int i = 0; i < 9; i++)
      present(3'(i % 8), mk(1'b0, 1'($urandom_range(0, 1)), 5'($urandom), 24'($urandom)));
    idle(3);
    chk("stream_count", 64'(bus.retire_count), 64'd9);
    chk("stream_order_err", 64'(bus.order_err), 64'd0);
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // Backpressure: slot is full and stalled, so the next head must wait.
    bus.retire_ready = 1'b0;
    a_data = mk(1'b0, 1'b1, 5'd17, 24'h5A5A01);
    b_data = mk(1'b0, 1'b0, 5'd9, 24'h123456);
    present(3'd1, a_data);
    bus.deq_valid = 1'b1;
    bus.deq_addr  = 3'd2;
    bus.deq_data  = b_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_deq_ready", 64'(bus.deq_ready), 64'd0);
      chk("bp_valid", 64'(bus.retire_valid), 64'd1);
      chk("bp_tag", 64'(bus.retire_tag), 64'd1);
      chk("bp_arch", 64'(bus.retire_rd_arch), 64'd17);
      chk("bp_pl", 64'(bus.retire_payload), 64'h5A5A01);
    end
    @(posedge clk); #1;
    bus.retire_ready = 1'b1;
    present(3'd2, b_data);
    idle(3);
    chk("bp_count", 64'(bus.retire_count), 64'd11);

    // Exception at head 3 with the handler stalling for two cycles.
    bus.exc_ready = 1'b0;
    present(3'd3, mk(1'b1, 1'b1, 5'd7, 24'hABCDEF));
    c_data = mk(1'b0, 1'b1, 5'd3, 24'h00C0DE);
    bus.deq_valid = 1'b1;
    bus.deq_addr  = 3'd0;
    bus.deq_data  = c_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("exc_valid", 64'(bus.exc_valid), 64'd1);
      chk("exc_tag", 64'(bus.exc_tag), 64'd3);
      chk("exc_pl", 64'(bus.exc_payload), 64'hABCDEF);
      chk("exc_deq_ready", 64'(bus.deq_ready), 64'd0);
      chk("exc_no_flush", 64'(bus.flush), 64'd0);
      chk("exc_no_retire", 64'(bus.retire_valid), 64'd0);
      if (i == 1) begin
        @(posedge clk); #1;
        bus.exc_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    bus.exc_ready = 1'b0;
    @(negedge clk);
    chk("flush_high", 64'(bus.flush), 64'd1);
    chk("flush_exc_clear", 64'(bus.exc_valid), 64'd0);
    chk("flush_deq_ready", 64'(bus.deq_ready), 64'd0);
    @(posedge clk); #1;
    present(3'd0, c_data);
    @(negedge clk);
    chk("flush_one_cycle", 64'(bus.flush), 64'd0);
    chk("exc_ptr_reset", 64'(bus.order_err), 64'd0);
    idle(3);
    chk("exc_count", 64'(bus.retire_count), 64'd12);

    // Head not done for four cycles.
    nd_data = mk(1'b0, 1'b0, 5'd30, 24'hFEED01);
    bus.deq_valid = 1'b1;
    bus.deq_addr  = 3'd1;
    bus.deq_data  = nd_data & ~32'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("nd_deq_ready", 64'(bus.deq_ready), 64'd0);
      chk("nd_retire_valid", 64'(bus.retire_valid), 64'd0);
    end
    @(posedge clk); #1;
    present(3'd1, nd_data);
    @(negedge clk);
    chk("nd_latency_valid", 64'(bus.retire_valid), 64'd1);
    chk("nd_latency_tag", 64'(bus.retire_tag), 64'd1);
    idle(3);
    chk("nd_count", 64'(bus.retire_count), 64'd13);

    // Order error is sticky until reset.
    do_reset();
    present(3'd5, mk(1'b0, 1'b1, 5'd4, 24'h000055));
    @(negedge clk);
    chk("oe_set", 64'(bus.order_err), 64'd1);
    @(posedge clk); #1;
    present(3'd6, mk(1'b0, 1'b0, 5'd5, 24'h000066));
    present(3'd7, mk(1'b0, 1'b1, 5'd6, 24'h000077));
    idle(3);
    chk("oe_sticky", 64'(bus.order_err), 64'd1);
    chk("oe_count", 64'(bus.retire_count), 64'd3);
    chk("oe_drained", 64'(sb.size()), 64'd0);
    do_reset();
    idle(2);
    chk("oe_cleared", 64'(bus.order_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
